pipe_addsub: RTL and testbench

Parametrised, pipelined integer adder/subtractor. It splits a WIDTH-bit operation into STAGES equal chunks, resolving one chunk per cycle with the carry registered between stages. Results carry carry-out, signed-overflow and zero flags. The block sits between the issue logic and writeback of the multi-cycle/pipelined datapath and replaces the single-cycle ripple adder where timing demands it. Input and output use valid/ready handshakes with full backpressure.

---
 rtl/pipe_addsub.sv | 126 ++++++++++++
 tb/tb_pipe_addsub.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, carry registered
// between stages, valid/ready handshake on both sides with full backpressure.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] fill;

    // fill[k]: stage k may take new contents this edge. That holds when the output is
    // being drained or any stage from k to the tail is empty, so bubbles collapse.
    always_comb begin
        logic tail_full;
        tail_full = 1'b1;
        fill      = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            tail_full = tail_full & v[k];
            fill[k]   = out_ready | ~tail_full;
        end
    end

    assign in_ready = fill[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k * CHUNK;  // operand bits not yet consumed

        logic                   src_v;
        logic                   src_c;
        logic [REM-1:0]         src_a;
        logic [REM-1:0]         src_b;
        logic [CHUNK-1:0]       chunk;
        logic                   carry;
        logic [(k+1)*CHUNK-1:0] res_new;
        logic [(k+1)*CHUNK-1:0] res_q;
        logic                   v_q;
        logic                   c_q;

        if (k == 0) begin : g_in
            assign src_v   = in_valid;
            assign src_a   = a;
            assign src_b   = sub ? ~b : b;
            assign src_c   = sub;
            assign res_new = chunk;
        end else begin : g_next
            assign src_v   = g_stage[k-1].v_q;
            assign src_a   = g_stage[k-1].g_up.a_up;
            assign src_b   = g_stage[k-1].g_up.b_up;
            assign src_c   = g_stage[k-1].c_q;
            assign res_new = {chunk, g_stage[k-1].res_q};
        end

        assign {carry, chunk} = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                              + {{CHUNK{1'b0}}, src_c};

        // NOTE: data registers are reset as well as the valid bits, so a reset pipeline
        // presents all-zero result fields rather than stale values from a flushed operation.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (fill[k]) begin
                v_q <= src_v;
                if (src_v) begin
                    c_q   <= carry;
                    res_q <= res_new;
                end
            end
        end

        assign v[k] = v_q;

        if (k < STAGES - 1) begin : g_up
            logic [REM-CHUNK-1:0] a_up;
            logic [REM-CHUNK-1:0] b_up;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_up <= '0;
                    b_up <= '0;
                end else if (fill[k] && src_v) begin
                    a_up <= src_a[REM-1:CHUNK];
                    b_up <= src_b[REM-1:CHUNK];
                end
            end
        end else begin : g_out
            logic ovf_q;
            logic zero_q;

            // In the last stage src_a/src_b are the top chunk, so bit CHUNK-1 is the operand msb.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (fill[k] && src_v) begin
                    ovf_q  <= (src_a[CHUNK-1] == src_b[CHUNK-1]) && (chunk[CHUNK-1] != src_a[CHUNK-1]);
                    zero_q <= (res_new == '0);
                end
            end

            assign out_valid = v_q;
            assign sum       = res_q;
            assign cout      = c_q;
            assign overflow  = ovf_q;
            assign zero      = zero_q;
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub: flag corner cases, backpressure ordering, mid-flight
// reset, and the single-stage configuration.
module tb_pipe_addsub;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;

    logic         s1_in_valid = 1'b0;
    logic         s1_in_ready;
    logic [W-1:0] s1_a = '0;
    logic [W-1:0] s1_b = '0;
    logic         s1_sub = 1'b0;
    logic         s1_out_valid;
    logic         s1_out_ready = 1'b1;
    logic [W-1:0] s1_sum;
    logic         s1_cout;
    logic         s1_overflow;
    logic         s1_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    pipe_addsub #(.WIDTH(W), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .a(s1_a), .b(s1_b), .sub(s1_sub),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .sum(s1_sum), .cout(s1_cout), .overflow(s1_overflow), .zero(s1_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One operation through the 4-stage instance with out_ready held high.
    task automatic single_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic ts, input logic [W-1:0] e_sum,
                             input logic e_cout, input logic e_ovf, input logic e_zero);
        int edges;
        @(posedge clk); #1;
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        @(negedge clk);
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(edges), 64'd4);
        check({tag, "_sum"}, 64'(sum), 64'(e_sum));
        check({tag, "_flags"}, 64'({cout, overflow, zero}), 64'({e_cout, e_ovf, e_zero}));
        @(posedge clk); #1;
    endtask

    initial begin
        int          edges;
        int          accepted;
        int          retired;
        int          ghosts;
        bit          seen_block;
        bit          held_ok;
        logic [34:0] held;
        logic [34:0] exp_q[$];

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'({sum, cout, overflow, zero}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_s1_out_valid", 64'(s1_out_valid), 64'd0);

        single_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        single_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single_op("sub_equal",  32'd5,         32'd5,         1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        single_op("sub_borrow", 32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Backpressure: 8 back-to-back ops, output stalled in cycles 2..7.
        accepted   = 0;
        retired    = 0;
        seen_block = 1'b0;
        held_ok    = 1'b0;
        held       = '0;
        for (int t = 1; t <= 40 && retired < 8; t++) begin
            out_ready = !(t >= 2 && t <= 7);
            in_valid  = (accepted < 8);
            a         = 32'(accepted + 1);
            b         = 32'(32'h100 * (accepted + 1));
            sub       = 1'b0;
            @(negedge clk);
            if (out_valid && !out_ready) begin
                if (held_ok) check("bp_hold", 64'({sum, cout, overflow, zero}), 64'(held));
                held    = {sum, cout, overflow, zero};
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            if (!in_ready && !seen_block) begin
                seen_block = 1'b1;
                check("bp_accepts_before_full", 64'(accepted), 64'd4);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({32'(32'h101 * (accepted + 1)), 3'b000});
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("bp_unexpected_result", 64'(exp_q.size()), 64'd1);
                else check($sformatf("bp_result%0d", retired + 1),
                           64'({sum, cout, overflow, zero}), 64'(exp_q.pop_front()));
                retired++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_full_seen", 64'(seen_block), 64'd1);
        check("bp_accepted", 64'(accepted), 64'd8);
        check("bp_retired", 64'(retired), 64'd8);
        @(negedge clk);
        check("bp_no_duplicate", 64'(out_valid), 64'd0);

        // Mid-flight reset with three ops queued behind a stalled output.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 32'(10 + i); b = 32'd0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid_now", 64'(out_valid), 64'd0);
        check("rst_data_cleared", 64'({sum, cout, overflow, zero}), 64'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        ghosts    = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) ghosts++;
            @(posedge clk); #1;
        end
        check("rst_no_ghosts", 64'(ghosts), 64'd0);
        single_op("after_rst", 32'h1234_0000, 32'h0000_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

        // Single-stage configuration: registered full-width adder.
        @(posedge clk); #1;
        s1_a = 32'h7FFF_FFFF; s1_b = 32'h0000_0001; s1_sub = 1'b0; s1_in_valid = 1'b1;
        @(negedge clk);
        check("s1_in_ready", 64'(s1_in_ready), 64'd1);
        @(posedge clk); #1;
        s1_in_valid = 1'b0;
        edges = 1;
        @(negedge clk);
        while (!s1_out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("s1_latency", 64'(edges), 64'd1);
        check("s1_sum", 64'(s1_sum), 64'h8000_0000);
        check("s1_flags", 64'({s1_cout, s1_overflow, s1_zero}), 64'b010);
        @(posedge clk); #1;
        @(negedge clk);
        check("s1_drained", 64'(s1_out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
